// File: rtl/gpio_input_conditioner.sv
// rtl/gpio_input_conditioner.sv - synchroniser, time-based debounce and edge pulses for board inputs
// Each bit is accepted only after holding a new level for STABLE_TICKS consecutive prescaler ticks.
module gpio_input_conditioner #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      SYNC_STAGES  = 2,
  parameter int unsigned      TICK_DIV     = 50000,
  parameter int unsigned      STABLE_TICKS = 10,
  parameter logic [WIDTH-1:0] RESET_LEVEL  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_i,
  input  logic [WIDTH-1:0] bypass_i,
  output logic [WIDTH-1:0] clean_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             changed_o,
  output logic             tick_o
);

  localparam int unsigned   PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned   CW      = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  sync;

  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;

  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         clean_q, clean_d;
  logic [WIDTH-1:0]         rise_q, rise_d;
  logic [WIDTH-1:0]         fall_q, fall_d;
  logic                     changed_q, changed_d;

  // Pure shift chain: stage 0 samples the pins, nothing sits between stages.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // tick_q is high in the cycle after the counter sat at its top value,
  // giving the first tick exactly TICK_DIV cycles after reset release.
  always_comb begin
    tick_d = (pre_q == PRE_MAX);
    pre_d  = tick_d ? '0 : pre_q + 1'b1;
  end

  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (bypass_i[i]) begin
        clean_d[i] = sync[i];
      end else if (sync[i] != clean_q[i]) begin
        if (!tick_q) begin
          cnt_d[i] = cnt_q[i];
        end else if (cnt_q[i] == CNT_MAX) begin
          clean_d[i] = sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    rise_d    = clean_d & ~clean_q;
    fall_d    = ~clean_d & clean_q;
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      pre_q     <= '0;
      tick_q    <= 1'b0;
      cnt_q     <= '0;
      clean_q   <= RESET_LEVEL;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign clean_o   = clean_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign changed_o = changed_q;
  assign tick_o    = tick_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb/tb_gpio_input_conditioner.sv - directed self-checking bench for gpio_input_conditioner
// WIDTH=4, SYNC_STAGES=2, TICK_DIV=4, STABLE_TICKS=3; edges are counted from reset release.
module tb_gpio_input_conditioner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] raw_i;
  logic [3:0] bypass_i;
  logic [3:0] clean_o;
  logic [3:0] rise_o;
  logic [3:0] fall_o;
  logic       changed_o;
  logic       tick_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gpio_input_conditioner #(
    .WIDTH       (4),
    .SYNC_STAGES (2),
    .TICK_DIV    (4),
    .STABLE_TICKS(3),
    .RESET_LEVEL (4'b0000)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw_i    (raw_i),
    .bypass_i (bypass_i),
    .clean_o  (clean_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .changed_o(changed_o),
    .tick_o   (tick_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] c, input logic [3:0] r,
                            input logic [3:0] f, input logic ch);
    check({tag, "/clean"},   32'(clean_o),   32'(c));
    check({tag, "/rise"},    32'(rise_o),    32'(r));
    check({tag, "/fall"},    32'(fall_o),    32'(f));
    check({tag, "/changed"}, 32'(changed_o), 32'(ch));
  endtask

  // Called right after release: ticks on edges 4 and 8 only.
  task automatic check_ticks();
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("tick_%0d", k), 32'(tick_o), 32'(k % 4 == 0));
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!tick_o && n < 8);
    check("wait_tick", 32'(tick_o), 32'(1'b1));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    raw_i    = 4'b0000;
    bypass_i = 4'b0000;
    repeat (3) step();
    expect_out("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    check("reset/tick", 32'(tick_o), 32'(1'b0));
    reset_n = 1'b1;
    check_ticks();

    // Clean press aligned to a tick at edge 8: accepted 13 edges later.
    raw_i[0] = 1'b1;
    repeat (12) step();
    expect_out("press_pre", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step();
    expect_out("press", 4'b0001, 4'b0001, 4'b0000, 1'b1);
    step();
    expect_out("press_post", 4'b0001, 4'b0000, 4'b0000, 1'b0);

    // Bounce 1,0,1,0 every 3 cycles then hold 1; final sync change at E+14, accept at E+25.
    wait_tick();
    raw_i[1] = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      check($sformatf("bounce_clean_%0d", k), 32'(clean_o), 32'(4'b0001));
      check($sformatf("bounce_changed_%0d", k), 32'(changed_o), 32'(1'b0));
      if (k == 3)       raw_i[1] = 1'b0;
      else if (k == 6)  raw_i[1] = 1'b1;
      else if (k == 9)  raw_i[1] = 1'b0;
      else if (k == 12) raw_i[1] = 1'b1;
    end
    step();
    expect_out("bounce_rise", 4'b0011, 4'b0010, 4'b0000, 1'b1);
    step();
    expect_out("bounce_post", 4'b0011, 4'b0000, 4'b0000, 1'b0);

    // Simultaneous release of bit 0 and press of bit 2.
    wait_tick();
    raw_i[0] = 1'b0;
    raw_i[2] = 1'b1;
    repeat (12) step();
    expect_out("simul_pre", 4'b0011, 4'b0000, 4'b0000, 1'b0);
    step();
    expect_out("simul", 4'b0110, 4'b0100, 4'b0001, 1'b1);
    step();
    expect_out("simul_post", 4'b0110, 4'b0000, 4'b0000, 1'b0);

    // Bypassed one-cycle pulse on bit 3.
    bypass_i[3] = 1'b1;
    step();
    raw_i[3] = 1'b1;
    step();
    raw_i[3] = 1'b0;
    step();
    expect_out("byp_b2", 4'b0110, 4'b0000, 4'b0000, 1'b0);
    step();
    expect_out("byp_rise", 4'b1110, 4'b1000, 4'b0000, 1'b1);
    step();
    expect_out("byp_fall", 4'b0110, 4'b0000, 4'b1000, 1'b1);
    step();
    expect_out("byp_post", 4'b0110, 4'b0000, 4'b0000, 1'b0);

    // Bypass cleared while the new level is still in the synchroniser: full debounce from 0.
    wait_tick();
    raw_i[3] = 1'b1;
    step();
    bypass_i[3] = 1'b0;
    repeat (2) step();
    expect_out("bypclr_e3", 4'b0110, 4'b0000, 4'b0000, 1'b0);
    repeat (9) step();
    expect_out("bypclr_pre", 4'b0110, 4'b0000, 4'b0000, 1'b0);
    step();
    expect_out("bypclr_rise", 4'b1110, 4'b1000, 4'b0000, 1'b1);
    step();
    expect_out("bypclr_post", 4'b1110, 4'b0000, 4'b0000, 1'b0);

    // Reset mid-run clears outputs without waiting for a clock edge.
    reset_n  = 1'b0;
    raw_i    = 4'b0000;
    bypass_i = 4'b0000;
    #1;
    expect_out("async_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    check("async_reset/tick", 32'(tick_o), 32'(1'b0));
    repeat (2) step();
    reset_n = 1'b1;
    check_ticks();

    // Reset mid-count discards the count; re-debounce takes the full time.
    raw_i[1] = 1'b1;
    repeat (7) step();
    reset_n = 1'b0;
    #1;
    expect_out("midcnt_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    repeat (2) step();
    expect_out("midcnt_hold", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("midcnt_clean_%0d", k), 32'(clean_o), 32'(4'b0000));
      check($sformatf("midcnt_changed_%0d", k), 32'(changed_o), 32'(1'b0));
    end
    step();
    expect_out("midcnt_rise", 4'b0010, 4'b0010, 4'b0000, 1'b1);
    step();
    expect_out("midcnt_post", 4'b0010, 4'b0000, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
